// File: rtl/video_if.sv
// Pixel-rate video stream: 24-bit RGB, active-low syncs and a visible-pixel flag.
interface video_if;
    logic        CLK;
    logic [23:0] RGB;
    logic        HS;
    logic        VS;
    logic        BLANK;

    modport master (output CLK, RGB, HS, VS, BLANK);
    modport slave  (input  CLK, RGB, HS, VS, BLANK);
endinterface

// File: rtl/video_overlay.sv
// Rectangle overlay (outline, optional 50% fill, blink) on the pixel stream,
// with line/frame geometry checking and a fixed two-cycle video delay.
module video_overlay #(
    parameter int HDISP        = 800,
    parameter int VDISP        = 480,
    parameter int BORDER       = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [23:0] rgb_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_in,
    input  logic [10:0] box_x,
    input  logic [10:0] box_w,
    input  logic [9:0]  box_y,
    input  logic [9:0]  box_h,
    input  logic [23:0] box_rgb,
    input  logic        box_en,
    input  logic        fill_en,
    input  logic        blink_en,
    input  logic        err_clr,
    output logic [1:0]  err,
    video_if.master     video_ifm
);

    localparam logic [10:0] L_HDISP      = 11'(HDISP);
    localparam logic [9:0]  L_VDISP      = 10'(VDISP);
    localparam logic [11:0] L_BORDER_X   = 12'(BORDER);
    localparam logic [10:0] L_BORDER_Y   = 11'(BORDER);
    localparam logic [15:0] L_BLINK_LAST = 16'(BLINK_FRAMES - 1);

    function automatic logic [23:0] blend_half(input logic [23:0] a, input logic [23:0] b);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] bl;
        r  = (a[23:16] >> 3'd1) + (b[23:16] >> 3'd1);
        g  = (a[15:8]  >> 3'd1) + (b[15:8]  >> 3'd1);
        bl = (a[7:0]   >> 3'd1) + (b[7:0]   >> 3'd1);
        return {r, g, bl};
    endfunction

    logic [23:0] r1_rgb;
    logic        r1_hs, r1_vs, r1_blank;
    logic [10:0] r1_x;
    logic [9:0]  r1_y;
    logic [10:0] r_xcnt;
    logic [9:0]  r_ycnt;
    logic        r_seen_fs, r_phase;
    logic [15:0] r_fcnt;
    logic [1:0]  r_err;
    logic [10:0] r_sh_x, r_sh_w;
    logic [9:0]  r_sh_y, r_sh_h;
    logic [23:0] r_sh_rgb;
    logic        r_sh_en, r_sh_fill, r_sh_blink;
    logic [23:0] r2_rgb;
    logic        r2_hs, r2_vs, r2_blank;

    logic        w_frame_start, w_line_end, w_line_err, w_frame_err;
    logic [9:0]  w_y;
    logic [11:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_visible, w_inside, w_border;
    logic [23:0] w_rgb;

    // r1_vs / r1_blank double as the previous-cycle copies for edge detection
    assign w_frame_start = r1_vs & ~vs_in;
    assign w_line_end    = r1_blank & ~blank_in;
    assign w_y           = w_frame_start ? 10'd0 : r_ycnt;
    assign w_line_err    = w_line_end & r_seen_fs & (r_xcnt != L_HDISP);
    assign w_frame_err   = w_frame_start & r_seen_fs & (r_ycnt != L_VDISP);

    // Stage 1: register the incoming pixel together with its coordinates
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r1_rgb   <= 24'h000000;
            r1_hs    <= 1'b1;
            r1_vs    <= 1'b1;
            r1_blank <= 1'b0;
            r1_x     <= 11'd0;
            r1_y     <= 10'd0;
        end else begin
            r1_rgb   <= rgb_in;
            r1_hs    <= hs_in;
            r1_vs    <= vs_in;
            r1_blank <= blank_in;
            r1_x     <= r_xcnt;
            r1_y     <= w_y;
        end
    end

    // Visible-pixel and visible-line counters, both saturating
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_xcnt <= 11'd0;
            r_ycnt <= 10'd0;
        end else begin
            if (blank_in) begin
                if (r_xcnt != 11'h7FF) begin
                    r_xcnt <= r_xcnt + 11'd1;
                end
            end else begin
                r_xcnt <= 11'd0;
            end
            if (w_frame_start) begin
                r_ycnt <= 10'd0;
            end else if (w_line_end && (r_ycnt != 10'h3FF)) begin
                r_ycnt <= r_ycnt + 10'd1;
            end
        end
    end

    // Sticky geometry errors; a new error beats a simultaneous clear
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_err <= 2'b00;
        end else begin
            r_err[0] <= w_line_err  | (r_err[0] & ~err_clr);
            r_err[1] <= w_frame_err | (r_err[1] & ~err_clr);
        end
    end

    // Frame-start bookkeeping: config shadows and blink phase; the first
    // frame start after reset only arms checking and does not count.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_seen_fs  <= 1'b0;
            r_phase    <= 1'b1;
            r_fcnt     <= 16'd0;
            r_sh_x     <= 11'd0;
            r_sh_w     <= 11'd0;
            r_sh_y     <= 10'd0;
            r_sh_h     <= 10'd0;
            r_sh_rgb   <= 24'h000000;
            r_sh_en    <= 1'b0;
            r_sh_fill  <= 1'b0;
            r_sh_blink <= 1'b0;
        end else if (w_frame_start) begin
            r_seen_fs  <= 1'b1;
            r_sh_x     <= box_x;
            r_sh_w     <= box_w;
            r_sh_y     <= box_y;
            r_sh_h     <= box_h;
            r_sh_rgb   <= box_rgb;
            r_sh_en    <= box_en;
            r_sh_fill  <= fill_en;
            r_sh_blink <= blink_en;
            if (r_seen_fs) begin
                if (r_fcnt == L_BLINK_LAST) begin
                    r_fcnt  <= 16'd0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 16'd1;
                end
            end
        end
    end

    // Widened sums let the box run off the right/bottom edge without wrapping
    assign w_x_end   = {1'b0, r_sh_x} + {1'b0, r_sh_w};
    assign w_y_end   = {1'b0, r_sh_y} + {1'b0, r_sh_h};
    assign w_visible = r_sh_en & (r_sh_w != 11'd0) & (r_sh_h != 10'd0) & (~r_sh_blink | r_phase);
    assign w_inside  = w_visible & (r1_x >= r_sh_x) & ({1'b0, r1_x} < w_x_end)
                                 & (r1_y >= r_sh_y) & ({1'b0, r1_y} < w_y_end);
    assign w_border  = w_inside & (({1'b0, r1_x} < ({1'b0, r_sh_x} + L_BORDER_X))
                                 | (({1'b0, r1_x} + L_BORDER_X) >= w_x_end)
                                 | ({1'b0, r1_y} < ({1'b0, r_sh_y} + L_BORDER_Y))
                                 | (({1'b0, r1_y} + L_BORDER_Y) >= w_y_end));

    // Output colour selection for the stage-1 pixel
    always_comb begin
        w_rgb = r1_rgb;
        if (!r1_blank) begin
            w_rgb = 24'h000000;
        end else if (w_border) begin
            w_rgb = r_sh_rgb;
        end else if (w_inside && r_sh_fill) begin
            w_rgb = blend_half(r1_rgb, r_sh_rgb);
        end else begin
            w_rgb = r1_rgb;
        end
    end

    // Stage 2: registered video outputs
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r2_rgb   <= 24'h000000;
            r2_hs    <= 1'b1;
            r2_vs    <= 1'b1;
            r2_blank <= 1'b0;
        end else begin
            r2_rgb   <= w_rgb;
            r2_hs    <= r1_hs;
            r2_vs    <= r1_vs;
            r2_blank <= r1_blank;
        end
    end

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.RGB   = r2_rgb;
    assign video_ifm.HS    = r2_hs;
    assign video_ifm.VS    = r2_vs;
    assign video_ifm.BLANK = r2_blank;
    assign err             = r_err;

endmodule

// File: tb/tb_video_overlay.sv
// Directed bench for video_overlay on a reduced 32x16 raster (box coordinates
// scaled down accordingly); output pixels are captured by bench-known coordinates.
module tb_video_overlay;
    localparam int HD = 32;
    localparam int VD = 16;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b0;
    logic [23:0] rgb_in    = 24'h000000;
    logic        hs_in     = 1'b1;
    logic        vs_in     = 1'b1;
    logic        blank_in  = 1'b0;
    logic [10:0] box_x     = 11'd0;
    logic [10:0] box_w     = 11'd0;
    logic [9:0]  box_y     = 10'd0;
    logic [9:0]  box_h     = 10'd0;
    logic [23:0] box_rgb   = 24'h000000;
    logic        box_en    = 1'b0;
    logic        fill_en   = 1'b0;
    logic        blink_en  = 1'b0;
    logic        err_clr   = 1'b0;
    logic [1:0]  err;

    video_if vif ();

    video_overlay #(.HDISP(HD), .VDISP(VD), .BORDER(2), .BLINK_FRAMES(2)) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .rgb_in(rgb_in), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .box_x(box_x), .box_w(box_w), .box_y(box_y), .box_h(box_h),
        .box_rgb(box_rgb), .box_en(box_en), .fill_en(fill_en), .blink_en(blink_en),
        .err_clr(err_clr), .err(err), .video_ifm(vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_chk  = 0;
    int n_err  = 0;
    int pt_err = 0;
    bit pt_mode = 1'b0;
    int cur_x = -1;
    int cur_y = -1;

    logic [23:0] h1_rgb = 24'h0, h2_rgb = 24'h0;
    logic        h1_hs = 1'b1, h2_hs = 1'b1, h1_vs = 1'b1, h2_vs = 1'b1;
    logic        h1_bl = 1'b0, h2_bl = 1'b0;
    int          h1_x = -1, h2_x = -1, h1_y = -1, h2_y = -1;

    logic [23:0] obuf [0:VD-1][0:HD-1];
    logic [1:0]  err_line [0:VD-1];
    logic [1:0]  err_vb;

    // Two-deep history of what was driven, to line up with the DUT output
    always @(posedge pixel_clk) begin
        h2_rgb <= h1_rgb; h2_hs <= h1_hs; h2_vs <= h1_vs; h2_bl <= h1_bl;
        h2_x   <= h1_x;   h2_y  <= h1_y;
        h1_rgb <= rgb_in; h1_hs <= hs_in; h1_vs <= vs_in; h1_bl <= blank_in;
        h1_x   <= cur_x;  h1_y  <= cur_y;
    end

    always @(negedge pixel_clk) begin
        if (pt_mode && ({vif.RGB, vif.HS, vif.VS, vif.BLANK} !== {h2_rgb, h2_hs, h2_vs, h2_bl}))
            pt_err = pt_err + 1;
        if (h2_bl && h2_x >= 0 && h2_x < HD && h2_y >= 0 && h2_y < VD)
            obuf[h2_y][h2_x] = vif.RGB;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic px(input logic vis, input logic hs, input logic vs, input logic [23:0] c,
                      input int x, input int y);
        @(posedge pixel_clk);
        #1;
        blank_in = vis;
        hs_in    = hs;
        vs_in    = vs;
        rgb_in   = vis ? c : 24'h000000;
        cur_x    = vis ? x : -1;
        cur_y    = vis ? y : -1;
    endtask

    task automatic do_line(input int nvis, input int y, input logic vs, input logic [23:0] c,
                           input bit rnd, input int rst_at);
        for (int i = 0; i < nvis; i++) begin
            px(1'b1, 1'b1, vs, rnd ? 24'($urandom) : c, i, y);
            if (i == rst_at) begin
                #1 pixel_rst = 1'b1;
                #1;
                check("midrst_rgb", vif.RGB, 32'h0);
                check("midrst_hs", vif.HS, 32'h1);
                check("midrst_vs", vif.VS, 32'h1);
                check("midrst_blank", vif.BLANK, 32'h0);
                check("midrst_err", err, 32'h0);
                @(negedge pixel_clk);
                pixel_rst = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++)
            px(1'b0, (i == 2 || i == 3) ? 1'b0 : 1'b1, vs, 24'h0, -1, -1);
    endtask

    task automatic send_frame(input int nlines, input int short_line, input logic [23:0] c,
                              input bit rnd, input int chg_line, input logic [10:0] chg_x,
                              input int rst_line);
        for (int yy = 0; yy < VD; yy++)
            for (int xx = 0; xx < HD; xx++)
                obuf[yy][xx] = 24'h5A5A5A;
        do_line(0, -1, 1'b1, c, rnd, -1);
        do_line(0, -1, 1'b0, c, rnd, -1);
        do_line(0, -1, 1'b1, c, rnd, -1);
        err_vb = err;
        for (int l = 0; l < nlines; l++) begin
            if (l == chg_line) box_x = chg_x;
            do_line((l == short_line) ? HD - 1 : HD, l, 1'b1, c, rnd, (l == rst_line) ? 10 : -1);
            if (l < VD) err_line[l] = err;
        end
    endtask

    task automatic frame_c(input logic [23:0] c);
        send_frame(VD, -1, c, 1'b0, -1, 11'd0, -1);
    endtask

    task automatic pulse_clr();
        @(posedge pixel_clk); #1 err_clr = 1'b1;
        @(posedge pixel_clk); #1 err_clr = 1'b0;
        @(negedge pixel_clk);
    endtask

    initial begin
        #2 pixel_rst = 1'b1;
        @(negedge pixel_clk);
        check("rst_rgb", vif.RGB, 32'h0);
        check("rst_hs", vif.HS, 32'h1);
        check("rst_vs", vif.VS, 32'h1);
        check("rst_blank", vif.BLANK, 32'h0);
        check("rst_err", err, 32'h0);
        @(negedge pixel_clk);
        pixel_rst = 1'b0;

        // Passthrough, random pixels, no overlay
        pt_mode = 1'b1;
        send_frame(VD, -1, 24'h0, 1'b1, -1, 11'd0, -1);
        send_frame(VD, -1, 24'h0, 1'b1, -1, 11'd0, -1);
        repeat (4) px(1'b0, 1'b1, 1'b1, 24'h0, -1, -1);
        pt_mode = 1'b0;
        check("pt_mismatches", pt_err, 32'd0);
        check("pt_err", err, 32'h0);

        // Outline
        box_x = 11'd4; box_w = 11'd20; box_y = 10'd3; box_h = 10'd10;
        box_rgb = 24'hFF0000; box_en = 1'b1;
        frame_c(24'h000000);
        check("ol_4_3", obuf[3][4], 32'hFF0000);
        check("ol_6_5", obuf[5][6], 32'h000000);
        check("ol_23_12", obuf[12][23], 32'hFF0000);
        check("ol_24_3", obuf[3][24], 32'h000000);
        check("ol_5_8", obuf[8][5], 32'hFF0000);
        check("ol_22_8", obuf[8][22], 32'hFF0000);
        check("ol_21_8", obuf[8][21], 32'h000000);
        check("ol_4_13", obuf[13][4], 32'h000000);

        // Blended fill
        fill_en = 1'b1; box_rgb = 24'h000080;
        frame_c(24'hFFFFFF);
        check("fill_10_7", obuf[7][10], 32'h7F7FBF);
        check("fill_border", obuf[3][4], 32'h000080);
        check("fill_out_0_0", obuf[0][0], 32'hFFFFFF);
        check("fill_out_30_15", obuf[15][30], 32'hFFFFFF);

        // Shadowing: mid-frame move only takes effect next frame
        fill_en = 1'b0; box_rgb = 24'hFF0000; box_x = 11'd4;
        send_frame(VD, -1, 24'h0, 1'b0, 5, 11'd14, -1);
        check("sh_cur_4_8", obuf[8][4], 32'hFF0000);
        check("sh_cur_14_8", obuf[8][14], 32'h000000);
        frame_c(24'h000000);
        check("sh_next_14_8", obuf[8][14], 32'hFF0000);
        check("sh_next_4_8", obuf[8][4], 32'h000000);

        // Geometry errors
        box_en = 1'b0;
        send_frame(VD, 5, 24'h0, 1'b0, -1, 11'd0, -1);
        check("err_before_short", err_line[4], 32'h0);
        check("err_after_short", err_line[5], 32'h1);
        frame_c(24'h000000);
        check("err_sticky", err_vb, 32'h1);
        pulse_clr();
        check("err_clr1", err, 32'h0);
        send_frame(VD - 1, -1, 24'h0, 1'b0, -1, 11'd0, -1);
        check("err_short_frame_lines", err_line[VD-2], 32'h0);
        frame_c(24'h000000);
        check("err_frame", err_vb, 32'h2);
        pulse_clr();
        check("err_clr2", err, 32'h0);

        // Blink with two-frame half period, from reset
        @(posedge pixel_clk); #1 pixel_rst = 1'b1;
        @(negedge pixel_clk); pixel_rst = 1'b0;
        box_x = 11'd4; box_en = 1'b1; blink_en = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            frame_c(24'h000000);
            check($sformatf("blink_f%0d", f), obuf[3][4], (f == 3 || f == 4) ? 32'h0 : 32'hFF0000);
        end

        // Reset in the middle of line 8
        blink_en = 1'b0;
        send_frame(VD, -1, 24'h0, 1'b0, -1, 11'd0, 8);
        check("mr_before", obuf[3][4], 32'hFF0000);
        check("mr_after", obuf[10][4], 32'h000000);
        check("mr_err0", err, 32'h0);
        frame_c(24'h000000);
        check("mr_next_overlay", obuf[10][4], 32'hFF0000);
        check("mr_next_err", err_vb, 32'h0);
        frame_c(24'h000000);
        check("mr_full_frame_err", err_vb, 32'h0);
        check("mr_final_err", err, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/video_overlay.md
# video_overlay

Pixel-domain post-processing stage between the VGA timing/framebuffer reader and the LCD/DAC pins. It takes the reader's RGB/HS/VS/BLANK stream, rebuilds the visible-pixel coordinates, and draws a configurable rectangle over the picture. The rectangle is an outline, optionally with a 50 % blended fill, and can blink. It also checks that every line and every frame has the nominal geometry, and delays all video signals equally.

## Interface
- HDISP, 800, visible pixels per line
- VDISP, 480, visible lines per frame
- BORDER, 2, outline thickness in pixels (1..15)
- BLINK_FRAMES, 30, frames per blink half-period (>=1)

- pixel_clk  in  1  pixel clock, all logic on rising edge
- pixel_rst  in  1  asynchronous, active-high reset
- rgb_in  in  24  upstream pixel {R,G,B}, 8 bits each
- hs_in, vs_in  in  1  upstream syncs, active-low
- blank_in  in  1  upstream visible flag, 1 = visible pixel
- box_x, box_w  in  11  rectangle left column, width (w=0 disables)
- box_y, box_h  in  10  rectangle top line, height (h=0 disables)
- box_rgb  in  24  rectangle colour
- box_en, fill_en, blink_en  in  1  draw enable, 50 % fill enable, blink enable
- err_clr  in  1  one-cycle pulse, clears err
- err  out  2  sticky flags: [0] line length error, [1] frame height error
- video_ifm  video_if.master  —  output stream; CLK driven by pixel_clk

## Operation
- Config shadowing: box_* and *_en are captured into shadow registers only at frame start. Frame start is the cycle where registered vs_in goes 1→0. Mid-frame changes never tear.
- Coordinate tracking, stage 1:
  - x = count of visible pixels so far in the line; 0 on the first blank_in=1 cycle; increments while blank_in=1; saturates at 2047.
  - y = index of the current visible line; increments at each blank_in 1→0 edge; reset to 0 at frame start; saturates at 1023.
- Line check: at each blank_in 1→0, if the line's visible count ≠ HDISP, set err[0].
- Frame check: at frame start, if the completed visible-line count ≠ VDISP, set err[1]. Skipped for the first frame after reset.
- err: bits are sticky. err_clr clears them; a set event in the same cycle as err_clr wins.
- Blink: a frame counter counts frame starts 0..BLINK_FRAMES-1. On wrap, phase toggles. phase resets to 1.
  - Box is visible when shadow box_en=1, w≠0, h≠0, and (blink_en=0 or phase=1).
- Hit test (x, y inside box): box_x ≤ x < box_x+box_w and box_y ≤ y < box_y+box_h. Sums are 12/11 bits, so the right and bottom edges clip naturally at the screen edge.
  - Border hit: inside the box and within BORDER of any edge.
- Output colour, stage 2:
  - blank=0 → 0.
  - Border hit → box_rgb.
  - Inside, not border, fill_en=1 → per channel (in>>1)+(box>>1), 8-bit, no overflow.
  - Otherwise → rgb_in.
- hs/vs/blank pass through unmodified, delayed to match.

## Timing
- Latency: exactly 2 cycles on RGB, HS, VS and BLANK. All four stay aligned.
- Output at cycle n+2 reflects the inputs at cycle n.
- Reset values: RGB=0, HS=1, VS=1, BLANK=0, err=0, x=y=0, phase=1, frame counter=0. Shadow box_en=0, so there is no overlay until the first frame start.
- Reset mid-frame: all state returns to the reset values at once. The first post-reset frame start reloads the shadows. Errors are suppressed until one full frame has been observed.
- Shadow load and the y reset happen in the same cycle. A pixel coinciding with the frame-start cycle uses the new configuration.
- No backpressure: one pixel in and one pixel out per cycle, unconditionally.

## Test plan
- Passthrough: box_en=0, run 2 nominal 800x480 frames (HFP 40 / HPULSE 48 / HBP 40 / VFP 13 / VPULSE 3 / VBP 29) → output equals input delayed by 2 cycles, bit-exact; err=0.
- Outline: box (100, 50, 20x10), BORDER=2, rgb_in=0x000000, box_rgb=0xFF0000.
  - Pixel (100,50) → FF0000; (102,52) → 000000; (119,59) → FF0000; (120,50) → 000000.
- Fill blend: fill_en=1, rgb_in=0xFFFFFF, box_rgb=0x000080 → box interior outputs 0x7F7FBF; pixels outside are unchanged.
- Shadowing and blink:
  - Change box_x from 100 to 300 mid-frame → the current frame still draws at 100; the next frame draws at 300.
  - blink_en=1, BLINK_FRAMES=2 → box is visible in frames 1-2, hidden in 3-4, visible in 5-6.
- Errors: one line with 799 visible pixels → err=01 after that line's blank fall. A frame with 479 lines → err[1] set at the next frame start. err_clr pulse → err=00.
- Reset mid-frame at line 200 → outputs take the reset values on the same edge; no overlay until the next frame start; no spurious err.
